ls_issue_unit: RTL

LS_ISSUE_UNIT -- requirements
Module: ls_issue_unit

---
 rtl/ls_issue_unit.sv | 243 ++++++++++++++++++++++++
 1 files changed

// File: rtl/ls_issue_unit.sv
// ls_issue_unit: load/store issue unit with an in-order store queue.
//
// Accepts one load or store at a time from the issue side (in_valid/in_ready).
// Loads take a single memory read cycle (LS_MemRead) and return their data one
// cycle later. Stores are checked and parked in the store queue, then written
// out to memory one entry per commit_store pulse (ROB_MemWrite). Faulting ops
// (misaligned, out of range, illegal funct3) respond with out_exc=1.
//
// Ports
//   clk, reset                  rising-edge clock, synchronous active-high reset
//   in_*                        issue-side op: kind, funct3, base, offset, data, tag
//   LS_MemRead/LS_result/func3_LS   load read request (byte address)
//   Data_memory_out             read data, registered by memory at end of request
//   commit_store, ROB_*         store-queue head write-out, same cycle as commit
//   out_valid/out_*             completion: tag, address, load data, exception
//   flush                       drop in-flight op and empty the store queue
module ls_issue_unit #(
    parameter int unsigned SQ_DEPTH  = 4,
    parameter int unsigned MEM_BYTES = 4096
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_is_store,
    input  logic [2:0]  in_funct3,
    input  logic [31:0] in_base,
    input  logic [31:0] in_offset,
    input  logic [31:0] in_store_data,
    input  logic [4:0]  in_rob_tag,
    output logic        LS_MemRead,
    output logic [31:0] LS_result,
    output logic [2:0]  func3_LS,
    input  logic [31:0] Data_memory_out,
    input  logic        commit_store,
    output logic        ROB_MemWrite,
    output logic [31:0] ROB_memadress,
    output logic [2:0]  ROB_funct3,
    output logic [31:0] out_value,
    output logic        out_valid,
    output logic [4:0]  out_rob_tag,
    output logic [31:0] out_addr,
    output logic [31:0] out_data,
    output logic        out_exc,
    input  logic        flush
);

    localparam int unsigned PW = $clog2(SQ_DEPTH);

    typedef enum logic [1:0] {StIdle, StRead, StResp} state_e;

    // Exclusive end of the byte range touched by an access; 33 bits so the
    // range never wraps when compared.
    function automatic logic [32:0] range_end(input logic [31:0] a, input logic [2:0] f3);
        logic [32:0] sz;
        case (f3[1:0])
            2'b00:   sz = 33'd1;
            2'b01:   sz = 33'd2;
            default: sz = 33'd4;
        endcase
        return {1'b0, a} + sz;
    endfunction

    state_e r_state;
    state_e w_state_d;

    logic [31:0] r_addr;
    logic [2:0]  r_funct3;
    logic [4:0]  r_tag;
    logic        r_exc;
    logic        r_is_load;

    logic [31:0] r_sq_addr [SQ_DEPTH];
    logic [2:0]  r_sq_f3   [SQ_DEPTH];
    logic [31:0] r_sq_data [SQ_DEPTH];
    logic [SQ_DEPTH-1:0] r_sq_vld;
    logic [PW-1:0] r_head;
    logic [PW-1:0] r_tail;
    logic [PW:0]   r_count;

    logic [31:0] w_addr;
    logic [32:0] w_end;
    logic        w_f3_legal;
    logic        w_misalign;
    logic        w_oob;
    logic        w_exc;
    logic        w_overlap;
    logic        w_full;
    logic        w_ready;
    logic        w_accept;
    logic        w_push;
    logic        w_commit;

    // ---------------------------------------------------------------- decode
    assign w_addr = in_base + in_offset;
    assign w_end  = range_end(w_addr, in_funct3);

    always_comb begin
        w_f3_legal = 1'b0;
        case (in_funct3)
            3'b000, 3'b001, 3'b010: w_f3_legal = 1'b1;
            3'b100, 3'b101:         w_f3_legal = ~in_is_store;
            default:                w_f3_legal = 1'b0;
        endcase
    end

    assign w_misalign = ((in_funct3[1:0] == 2'b01) && w_addr[0]) ||
                        ((in_funct3[1:0] == 2'b10) && (w_addr[1:0] != 2'b00));
    assign w_oob      = w_end > 33'(MEM_BYTES);
    assign w_exc      = ~w_f3_legal | w_misalign | w_oob;

    // A load may not pass any queued store touching one of its bytes.
    always_comb begin
        w_overlap = 1'b0;
        for (int i = 0; i < int'(SQ_DEPTH); i++) begin
            if (r_sq_vld[i] &&
                ({1'b0, w_addr} < range_end(r_sq_addr[i], r_sq_f3[i])) &&
                ({1'b0, r_sq_addr[i]} < w_end)) begin
                w_overlap = 1'b1;
            end
        end
    end

    assign w_full   = (r_count == (PW+1)'(SQ_DEPTH));
    // A commit in the same cycle frees a slot, so a full queue can still take a store.
    assign w_ready  = ~reset & ~flush & (r_state == StIdle) &
                      (in_is_store ? (~w_full | commit_store) : ~w_overlap);
    assign w_accept = in_valid & w_ready;
    assign w_push   = w_accept & in_is_store & ~w_exc;
    assign w_commit = commit_store & (r_count != '0) & ~reset;

    assign in_ready = w_ready;

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_d;
        end
    end

    always_comb begin
        w_state_d = r_state;
        case (r_state)
            StIdle: begin
                if (w_accept) begin
                    w_state_d = (in_is_store || w_exc) ? StResp : StRead;
                end
            end
            StRead:  w_state_d = StResp;
            StResp:  w_state_d = StIdle;
            default: w_state_d = StIdle;
        endcase
        if (flush) begin
            w_state_d = StIdle;
        end
    end

    always_comb begin
        LS_MemRead  = 1'b0;
        LS_result   = '0;
        func3_LS    = '0;
        out_valid   = 1'b0;
        out_rob_tag = '0;
        out_addr    = '0;
        out_data    = '0;
        out_exc     = 1'b0;
        if (!reset && !flush) begin
            case (r_state)
                StRead: begin
                    LS_MemRead = 1'b1;
                    LS_result  = r_addr;
                    func3_LS   = r_funct3;
                end
                StResp: begin
                    out_valid   = 1'b1;
                    out_rob_tag = r_tag;
                    out_addr    = r_addr;
                    out_exc     = r_exc;
                    out_data    = (r_is_load && !r_exc) ? Data_memory_out : 32'h0;
                end
                default: ;
            endcase
        end
    end

    // Captured op travelling through READ/RESP.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_addr    <= '0;
            r_funct3  <= '0;
            r_tag     <= '0;
            r_exc     <= 1'b0;
            r_is_load <= 1'b0;
        end else if (w_accept) begin
            r_addr    <= w_addr;
            r_funct3  <= in_funct3;
            r_tag     <= in_rob_tag;
            r_exc     <= w_exc;
            r_is_load <= ~in_is_store;
        end
    end

    // ---------------------------------------------------------------- store queue
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            r_sq_vld <= '0;
            r_head   <= '0;
            r_tail   <= '0;
            r_count  <= '0;
        end else begin
            if (w_commit) begin
                r_sq_vld[r_head] <= 1'b0;
                r_head           <= r_head + 1'b1;
            end
            // Ordered after the pop so a full-queue push+pop keeps the slot valid.
            if (w_push) begin
                r_sq_vld[r_tail] <= 1'b1;
                r_tail           <= r_tail + 1'b1;
            end
            case ({w_push, w_commit})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_sq_addr[r_tail] <= w_addr;
            r_sq_f3[r_tail]   <= in_funct3;
            r_sq_data[r_tail] <= in_store_data;
        end
    end

    assign ROB_MemWrite  = w_commit;
    assign ROB_memadress = w_commit ? r_sq_addr[r_head] : 32'h0;
    assign ROB_funct3    = w_commit ? r_sq_f3[r_head]   : 3'h0;
    assign out_value     = w_commit ? r_sq_data[r_head] : 32'h0;

endmodule
